// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states, width default.
package riscv_m_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

  function automatic logic is_div_op(logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on magnitudes.
module muldiv_iter_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  input  logic            div_mode,
  output logic [XLEN-1:0] next_acc,
  output logic [XLEN-1:0] next_lo,
  output logic            q_bit
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    sum      = {1'b0, acc} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted  = {acc, acc_lo[XLEN-1]};
    // Modular subtract is exact whenever the trial fits, since remainder < divisor.
    diff     = shifted[XLEN-1:0] - operand;
    fits     = shifted >= {1'b0, operand};
    next_acc = '0;
    next_lo  = '0;
    q_bit    = 1'b0;
    if (div_mode) begin
      q_bit    = fits;
      next_acc = fits ? diff : shifted[XLEN-1:0];
      next_lo  = {acc_lo[XLEN-2:0], 1'b0};
    end else begin
      next_acc = sum[XLEN:1];
      next_lo  = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: XLEN RUN cycles, one FIX cycle, fixed latency XLEN+2.
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   hi_q, lo_q, opnd_q, a_raw_q, result_q;
  logic              neg_a_q, neg_b_q, b_zero_q, ovf_q;

  logic              accept, signed_a, signed_b, neg_a, neg_b, ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_mode, step_q;
  logic [XLEN-1:0]   step_acc, step_lo, lo_d;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_result;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    neg_a    = signed_a && op_a[XLEN-1];
    neg_b    = signed_b && op_b[XLEN-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (op_a == MinNeg) && (op_b == '1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (count_q == LastCnt) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign div_mode = is_div_op(f3_q);

  muldiv_iter_step #(
    .XLEN(XLEN)
  ) u_step (
    .acc     (hi_q),
    .acc_lo  (lo_q),
    .operand (opnd_q),
    .div_mode(div_mode),
    .next_acc(step_acc),
    .next_lo (step_lo),
    .q_bit   (step_q)
  );

  // Divide shifts quotient bits in at the bottom as dividend bits leave the top.
  assign lo_d = div_mode ? {step_lo[XLEN-1:1], step_q} : step_lo;

  always_comb begin
    prod       = {hi_q, lo_q};
    prod_s     = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_s      = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem_s      = neg_a_q ? -hi_q : hi_q;
    fix_result = '0;
    case (f3_q)
      F3_MUL:                        fix_result = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_result = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fix_result = b_zero_q ? '1 : (ovf_q ? MinNeg : quo_s);
      F3_REM, F3_REMU:               fix_result = b_zero_q ? a_raw_q : (ovf_q ? '0 : rem_s);
      default:                       fix_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      f3_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q     <= funct3;
        hi_q     <= '0;
        lo_q     <= mag_a;
        opnd_q   <= mag_b;
        a_raw_q  <= op_a;
        neg_a_q  <= neg_a;
        neg_b_q  <= neg_b;
        b_zero_q <= (op_b == '0);
        ovf_q    <= ovf;
        count_q  <= '0;
      end else if (state_q == StRun) begin
        hi_q    <= step_acc;
        lo_q    <= lo_d;
        count_q <= (count_q == LastCnt) ? count_q : count_q + 1'b1;
      end
      if (state_q == StFix) begin
        result_q <= fix_result;
      end
    end
  end

  assign busy   = (state_q == StRun) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, handshake/reset sequences, random ops.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct3(funct3),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    int                 ia, ib;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      MUL:    begin up = ua * ub; return up[31:0]; end
      MULH:   begin sp = sa * sb; return sp[63:32]; end
      MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
      MULHU:  begin up = ua * ub; return up[63:32]; end
      DIV:    return (b == 0) ? 32'hFFFF_FFFF :
                     ((a == MINV && b == 32'hFFFF_FFFF) ? MINV : 32'(ia / ib));
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    return (b == 0) ? a : ((a == MINV && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request now; it is accepted on the next rising edge. Operands are scrambled after.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  // Cycle 1 is the cycle right after the accept edge. Returns in the done cycle.
  task automatic wait_done(input int repulse_at, output logic [31:0] res, output int done_cyc,
                           output logic busy_ok);
    done_cyc = -1;
    busy_ok  = 1'b1;
    res      = 'x;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        res      = result;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (cyc == repulse_at) begin
        start  = 1'b1;
        funct3 = DIV;
        op_a   = 32'd9;
        op_b   = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a, b, exp);
    logic [31:0] res;
    int          dc;
    logic        bok;
    issue(f, a, b);
    wait_done(0, res, dc, bok);
    check({name, "_result"}, res, exp);
    check({name, "_latency"}, 32'(dc), 32'd34);
    check({name, "_busy"}, 32'(bok), 32'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] res, held;
    int          dc;
    logic        bok, saw_done;

    vecs.push_back('{MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{MULH,   MINV,         MINV,          32'h4000_0000});
    vecs.push_back('{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{DIVU,   32'd100,       32'd7,         32'd14});
    vecs.push_back('{REMU,   32'd100,       32'd7,         32'd2});
    vecs.push_back('{DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{REMU,   32'd5,         32'd0,         32'd5});
    vecs.push_back('{DIV,    MINV,          32'hFFFF_FFFF, MINV});
    vecs.push_back('{REM,    MINV,          32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9});

    reset  = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // done is a single pulse and result holds while idle.
    issue(MUL, 32'd6, 32'd7);
    wait_done(0, res, dc, bok);
    check("hold_first", res, 32'd42);
    @(posedge clk);
    #1;
    check("pulse_done_low", 32'(done), 32'd0);
    check("idle_busy_low", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", result, 32'd42);

    // start re-pulsed while busy must be ignored.
    issue(MUL, 32'd3, 32'd4);
    wait_done(10, res, dc, bok);
    check("repulse_result", res, 32'd12);
    check("repulse_latency", 32'(dc), 32'd34);

    // Back-to-back: new start accepted in the DONE cycle.
    @(posedge clk);
    #1;
    issue(DIVU, 32'd50, 32'd6);
    wait_done(0, res, dc, bok);
    check("b2b_first", res, 32'd8);
    check("b2b_done_seen", 32'(done), 32'd1);
    issue(MUL, 32'd5, 32'd6);
    wait_done(0, res, dc, bok);
    check("b2b_second", res, 32'd30);
    check("b2b_latency", 32'(dc), 32'd34);
    check("b2b_busy", 32'(bok), 32'd1);
    @(posedge clk);
    #1;

    // Reset during cycle 10 of a DIV aborts it.
    issue(DIV, 32'd1000, 32'd7);
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    do_op("after_reset", REM, 32'd1000, 32'd7, 32'd6);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = rand_operand();
      b = rand_operand();
      issue(f, a, b);
      wait_done(0, res, dc, bok);
      check($sformatf("rand%0d_f%0d_%08h_%08h", i, f, a, b), res, model(f, a, b));
      check($sformatf("rand%0d_latency", i), 32'(dc), 32'd34);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
